// File: rtl/axi_read_slave_if.sv
// AR/R channel bundle between a read master and axi_read_slave.
interface axi_read_slave_if #(
  parameter int BusWidth = 32,
  parameter int tagbits  = 1
);
  logic [tagbits-1:0]  ARID;
  logic [BusWidth-1:0] ARADDR;
  logic [3:0]          ARLEN;
  logic [1:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic [1:0]          ARLOCK;
  logic [3:0]          ARCACHE;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;
  logic [tagbits-1:0]  RID;
  logic [BusWidth-1:0] RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_read_slave.sv
// AXI3-style read slave: queues AR requests and returns R bursts in order
// from a word-addressed memory filled through a preload write port.
//
// state | meaning
// IDLE  | no burst in service, RVALID low; pops the queue head when present
// BURST | a beat is presented on R; advances on RVALID&RREADY
module axi_read_slave #(
  parameter int BusWidth = 32,
  parameter int tagbits  = 1,
  parameter int MemDepth = 64,
  parameter int QDepth   = 2
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  axi_read_slave_if.slave             bus,
  input  logic                        mem_we,
  input  logic [$clog2(MemDepth)-1:0] mem_waddr,
  input  logic [BusWidth-1:0]         mem_wdata
);
  localparam int AW = $clog2(MemDepth);
  localparam int WS = $clog2(BusWidth / 8);
  localparam int PW = (QDepth > 1) ? $clog2(QDepth) : 1;
  localparam int CW = $clog2(QDepth + 1);

  typedef struct packed {
    logic [tagbits-1:0]  id;
    logic [BusWidth-1:0] addr;
    logic [3:0]          len;
    logic [1:0]          size;
    logic [1:0]          burst;
  } req_t;

  typedef enum logic {IDLE, BURST} state_t;

  logic [BusWidth-1:0] mem [MemDepth];

  req_t          q [QDepth];
  req_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] q_count, count_next;
  logic          push, pop, advance, do_load;

  state_t              state;
  logic [tagbits-1:0]  cur_id;
  logic [BusWidth-1:0] cur_addr;
  logic [3:0]          cur_len;
  logic [1:0]          cur_size;
  logic [1:0]          cur_burst;
  logic [3:0]          beat;

  logic [BusWidth-1:0] step_b, wrap_mask, nxt_addr;
  logic [tagbits-1:0]  ld_id;
  logic [BusWidth-1:0] ld_addr, ld_idx, ld_data;
  logic [3:0]          ld_len, ld_beat;
  logic [1:0]          ld_size, ld_burst;
  logic                ld_last, ld_err, burst_bad, oob;

  // LOCK/CACHE/PROT carry no meaning for this memory model.
  logic ar_attr_unused;
  assign ar_attr_unused = ^{bus.ARLOCK, bus.ARCACHE, bus.ARPROT};

  always_ff @(posedge ACLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign push       = bus.ARVALID && bus.ARREADY;
  assign head       = q[rd_ptr];
  assign pop        = (q_count != '0) &&
                      ((state == IDLE) || (bus.RVALID && bus.RREADY && bus.RLAST));
  assign advance    = (state == BURST) && bus.RVALID && bus.RREADY && !bus.RLAST;
  assign do_load    = pop || advance;
  assign count_next = q_count + CW'(push) - CW'(pop);

  always_ff @(posedge ACLK) begin
    if (push) q[wr_ptr] <= '{id: bus.ARID, addr: bus.ARADDR, len: bus.ARLEN,
                             size: bus.ARSIZE, burst: bus.ARBURST};
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_count     <= '0;
      bus.ARREADY <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(QDepth - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(QDepth - 1)) ? '0 : rd_ptr + 1'b1;
      q_count     <= count_next;
      bus.ARREADY <= (count_next < CW'(QDepth));
    end
  end

  // WRAP keeps the upper address bits and lets the low bits roll inside the container.
  always_comb begin
    step_b    = BusWidth'(1) << cur_size;
    wrap_mask = ((BusWidth'(cur_len) + BusWidth'(1)) << cur_size) - BusWidth'(1);
    case (cur_burst)
      2'b00:   nxt_addr = cur_addr;
      2'b10:   nxt_addr = (cur_addr & ~wrap_mask) | ((cur_addr + step_b) & wrap_mask);
      default: nxt_addr = cur_addr + step_b;
    endcase
  end

  always_comb begin
    ld_id    = cur_id;
    ld_addr  = nxt_addr;
    ld_len   = cur_len;
    ld_size  = cur_size;
    ld_burst = cur_burst;
    ld_beat  = beat + 4'd1;
    if (pop) begin
      ld_id    = head.id;
      ld_addr  = head.addr;
      ld_len   = head.len;
      ld_size  = head.size;
      ld_burst = head.burst;
      ld_beat  = 4'd0;
    end
    ld_last   = (ld_beat == ld_len);
    burst_bad = (ld_burst == 2'b11) ||
                ((ld_burst == 2'b10) && !(ld_len inside {4'd1, 4'd3, 4'd7, 4'd15})) ||
                (int'(ld_size) > WS);
    ld_idx    = ld_addr >> WS;
    oob       = (ld_idx >= BusWidth'(MemDepth));
    ld_err    = burst_bad || oob;
    ld_data   = ld_err ? '0 : mem[ld_idx[AW-1:0]];
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      cur_id     <= '0;
      cur_addr   <= '0;
      cur_len    <= '0;
      cur_size   <= '0;
      cur_burst  <= '0;
      beat       <= '0;
      bus.RVALID <= 1'b0;
      bus.RLAST  <= 1'b0;
      bus.RID    <= '0;
      bus.RDATA  <= '0;
      bus.RRESP  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (do_load) state <= BURST;
        end
        BURST: begin
          if (bus.RVALID && bus.RREADY && bus.RLAST && !pop) begin
            state      <= IDLE;
            bus.RVALID <= 1'b0;
            bus.RLAST  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (do_load) begin
        cur_id     <= ld_id;
        cur_addr   <= ld_addr;
        cur_len    <= ld_len;
        cur_size   <= ld_size;
        cur_burst  <= ld_burst;
        beat       <= ld_beat;
        bus.RVALID <= 1'b1;
        bus.RLAST  <= ld_last;
        bus.RID    <= ld_id;
        bus.RDATA  <= ld_data;
        bus.RRESP  <= ld_err ? 2'b10 : 2'b00;
      end
    end
  end
endmodule

// File: tb/tb_axi_read_slave.sv
// Directed bench for axi_read_slave: memory word i is preloaded with 32'hD000_0000 + i.
module tb_axi_read_slave;
  logic       ACLK;
  logic       ARESETn;
  logic       mem_we;
  logic [5:0] mem_waddr;
  logic [31:0] mem_wdata;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_w [16];
  logic [1:0]  exp_r [16];
  logic        qf_id [6];
  logic [31:0] qf_w  [6];
  logic        qf_l  [6];

  axi_read_slave_if #(.BusWidth(32), .tagbits(1)) bus ();

  axi_read_slave #(.BusWidth(32), .tagbits(1), .MemDepth(64), .QDepth(2)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .bus       (bus),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ar_issue(input logic id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] size, input logic [1:0] burst);
    int n = 0;
    bus.ARID    = id;
    bus.ARADDR  = addr;
    bus.ARLEN   = len;
    bus.ARSIZE  = size;
    bus.ARBURST = burst;
    bus.ARLOCK  = 2'b01;
    bus.ARCACHE = 4'h3;
    bus.ARPROT  = 3'b010;
    bus.ARVALID = 1'b1;
    while (!bus.ARREADY && n < 50) begin
      step();
      n++;
    end
    check("ar_ready_wait", bus.ARREADY, 1);
    step();
    bus.ARVALID = 1'b0;
  endtask

  task automatic collect(input string tag, input logic id, input int n);
    int w = 0;
    bus.RREADY = 1'b1;
    while (!bus.RVALID && w < 50) begin
      step();
      w++;
    end
    for (int b = 0; b < n; b++) begin
      check($sformatf("%s_valid%0d", tag, b), bus.RVALID, 1);
      check($sformatf("%s_data%0d", tag, b), bus.RDATA, exp_w[b]);
      check($sformatf("%s_id%0d", tag, b), bus.RID, id);
      check($sformatf("%s_resp%0d", tag, b), bus.RRESP, exp_r[b]);
      check($sformatf("%s_last%0d", tag, b), bus.RLAST, (b == n - 1));
      step();
    end
    check($sformatf("%s_end", tag), bus.RVALID, 0);
  endtask

  initial begin
    int b;
    int k;
    logic hs;

    ARESETn     = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;
    bus.ARID    = '0;
    bus.ARADDR  = '0;
    bus.ARLEN   = '0;
    bus.ARSIZE  = '0;
    bus.ARBURST = '0;
    bus.ARLOCK  = '0;
    bus.ARCACHE = '0;
    bus.ARPROT  = '0;
    bus.ARVALID = 1'b0;
    bus.RREADY  = 1'b0;

    for (int i = 0; i < 64; i++) begin
      mem_we    = 1'b1;
      mem_waddr = 6'(i);
      mem_wdata = 32'hD000_0000 + 32'(i);
      step();
    end
    mem_we = 1'b0;

    check("rst_arready", bus.ARREADY, 0);
    check("rst_rvalid", bus.RVALID, 0);
    check("rst_rlast", bus.RLAST, 0);
    check("rst_rid", bus.RID, 0);
    check("rst_rdata", bus.RDATA, 0);
    check("rst_rresp", bus.RRESP, 0);

    ARESETn = 1'b1;
    check("rel_arready0", bus.ARREADY, 0);
    step();
    check("rel_arready1", bus.ARREADY, 1);

    // INCR, with first-beat latency
    bus.RREADY = 1'b1;
    ar_issue(1'b1, 32'h10, 4'd3, 2'b10, 2'b01);
    check("incr_lat0", bus.RVALID, 0);
    step();
    check("incr_lat1", bus.RVALID, 1);
    exp_w[0] = 32'hD000_0004; exp_w[1] = 32'hD000_0005;
    exp_w[2] = 32'hD000_0006; exp_w[3] = 32'hD000_0007;
    for (int i = 0; i < 4; i++) exp_r[i] = 2'b00;
    collect("incr", 1'b1, 4);

    // WRAP 0x18, 4 beats of 4 bytes -> words 6,7,4,5
    ar_issue(1'b0, 32'h18, 4'd3, 2'b10, 2'b10);
    exp_w[0] = 32'hD000_0006; exp_w[1] = 32'hD000_0007;
    exp_w[2] = 32'hD000_0004; exp_w[3] = 32'hD000_0005;
    collect("wrap", 1'b0, 4);

    // FIXED
    ar_issue(1'b1, 32'h08, 4'd2, 2'b10, 2'b00);
    exp_w[0] = 32'hD000_0002; exp_w[1] = 32'hD000_0002; exp_w[2] = 32'hD000_0002;
    collect("fixed", 1'b1, 3);

    // Backpressure 1,0,0,1,... plus a preload write to the presented word while stalled
    bus.RREADY = 1'b0;
    ar_issue(1'b0, 32'h20, 4'd3, 2'b10, 2'b01);
    step();
    b = 0;
    k = 0;
    while (b < 4 && k < 30) begin
      check($sformatf("bp_valid_k%0d", k), bus.RVALID, 1);
      check($sformatf("bp_data_k%0d", k), bus.RDATA, 32'hD000_0008 + 32'(b));
      check($sformatf("bp_last_k%0d", k), bus.RLAST, (b == 3));
      check($sformatf("bp_id_k%0d", k), bus.RID, 0);
      bus.RREADY = (k % 3 == 0);
      mem_we     = (k == 1);
      mem_waddr  = 6'd9;
      mem_wdata  = 32'hBAD0_0000;
      hs         = bus.RVALID && bus.RREADY;
      step();
      mem_we = 1'b0;
      if (hs) b++;
      k++;
    end
    check("bp_beats", b, 4);
    check("bp_end", bus.RVALID, 0);

    // Queue full: three ARs while stalled, a fourth held pending
    bus.RREADY  = 1'b0;
    bus.ARSIZE  = 2'b10;
    bus.ARBURST = 2'b01;
    bus.ARID = 1'b0; bus.ARADDR = 32'h30; bus.ARLEN = 4'd1; bus.ARVALID = 1'b1;
    check("qf_rdy_a", bus.ARREADY, 1);
    step();
    bus.ARID = 1'b1; bus.ARADDR = 32'h40; bus.ARLEN = 4'd0;
    step();
    check("qf_first_valid", bus.RVALID, 1);
    check("qf_rdy_b", bus.ARREADY, 1);
    bus.ARID = 1'b0; bus.ARADDR = 32'h50; bus.ARLEN = 4'd1;
    step();
    check("qf_full", bus.ARREADY, 0);
    bus.ARID = 1'b1; bus.ARADDR = 32'h60; bus.ARLEN = 4'd0;
    step();
    check("qf_full_hold1", bus.ARREADY, 0);
    step();
    check("qf_full_hold2", bus.ARREADY, 0);
    check("qf_stall_data", bus.RDATA, 32'hD000_000C);
    qf_id[0] = 1'b0; qf_w[0] = 32'hD000_000C; qf_l[0] = 1'b0;
    qf_id[1] = 1'b0; qf_w[1] = 32'hD000_000D; qf_l[1] = 1'b1;
    qf_id[2] = 1'b1; qf_w[2] = 32'hD000_0010; qf_l[2] = 1'b1;
    qf_id[3] = 1'b0; qf_w[3] = 32'hD000_0014; qf_l[3] = 1'b0;
    qf_id[4] = 1'b0; qf_w[4] = 32'hD000_0015; qf_l[4] = 1'b1;
    qf_id[5] = 1'b1; qf_w[5] = 32'hD000_0018; qf_l[5] = 1'b1;
    bus.RREADY = 1'b1;
    b = 0;
    k = 0;
    while (b < 6 && k < 30) begin
      check($sformatf("qf_valid_k%0d", k), bus.RVALID, 1);
      if (bus.RVALID) begin
        check($sformatf("qf_id%0d", b), bus.RID, qf_id[b]);
        check($sformatf("qf_data%0d", b), bus.RDATA, qf_w[b]);
        check($sformatf("qf_last%0d", b), bus.RLAST, qf_l[b]);
      end
      hs = bus.ARVALID && bus.ARREADY;
      if (bus.RVALID) b++;
      step();
      if (hs) bus.ARVALID = 1'b0;
      k++;
    end
    check("qf_pending_taken", bus.ARVALID, 0);
    check("qf_end", bus.RVALID, 0);

    // Errors
    ar_issue(1'b1, 32'h100, 4'd1, 2'b10, 2'b01);
    exp_w[0] = 32'h0; exp_w[1] = 32'h0;
    exp_r[0] = 2'b10; exp_r[1] = 2'b10;
    collect("err_oob", 1'b1, 2);

    ar_issue(1'b0, 32'hFC, 4'd1, 2'b10, 2'b01);
    exp_w[0] = 32'hD000_003F; exp_r[0] = 2'b00;
    exp_w[1] = 32'h0;         exp_r[1] = 2'b10;
    collect("err_edge", 1'b0, 2);

    ar_issue(1'b1, 32'h10, 4'd2, 2'b10, 2'b10);
    for (int i = 0; i < 3; i++) begin
      exp_w[i] = 32'h0;
      exp_r[i] = 2'b10;
    end
    collect("err_wraplen", 1'b1, 3);

    ar_issue(1'b0, 32'h00, 4'd0, 2'b10, 2'b11);
    collect("err_burst11", 1'b0, 1);

    ar_issue(1'b1, 32'h00, 4'd0, 2'b11, 2'b01);
    collect("err_size8", 1'b1, 1);

    // Reset mid-burst with a second request queued
    bus.RREADY = 1'b0;
    ar_issue(1'b0, 32'h00, 4'd7, 2'b10, 2'b01);
    ar_issue(1'b1, 32'h20, 4'd0, 2'b10, 2'b01);
    step();
    check("mid_pre_valid", bus.RVALID, 1);
    ARESETn = 1'b0;
    #1;
    check("mid_rvalid", bus.RVALID, 0);
    check("mid_arready", bus.ARREADY, 0);
    check("mid_rlast", bus.RLAST, 0);
    step();
    ARESETn = 1'b1;
    step();
    check("mid_rel_arready", bus.ARREADY, 1);
    bus.RREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mid_empty%0d", i), bus.RVALID, 0);
      step();
    end
    ar_issue(1'b1, 32'h04, 4'd0, 2'b10, 2'b01);
    exp_w[0] = 32'hD000_0001; exp_r[0] = 2'b00;
    collect("post_rst", 1'b1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
